uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Parametrised UART transmit engine. It combines the transmit control FSM, the shift register and the bit counter into one block.
- Accepts a parallel word over a valid/ready handshake.
- Serialises it LSB-first with start bit, optional parity and 1 or 2 stop bits.
- Each bit boundary is aligned to an external single-cycle baud tick from the shared baud generator.
- Sits between the TX FIFO/host interface and the tx pad.

Parameters:
DATA_BITS, 8, payload width per frame; legal 5..9.
STOP_BITS, 1, number of stop bits; legal 1 or 2.
CNT_W, 4, bit counter width; must satisfy 2^CNT_W > DATA_BITS.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
baud  input  1  one-clk-wide pulse marking each bit-period boundary
tx_data  input  DATA_BITS  word to send; sampled on handshake
tx_valid  input  1  producer has a word
tx_ready  output  1  engine can accept a word (registered)
parity_odd  input  1  0 = even parity, 1 = odd; sampled on handshake (used only when parity feature compiled in)
tx  output  1  serial line, idle high (registered)
busy  output  1  high from handshake until frame end
done  output  1  one-clk pulse when final stop bit period ends

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, tx=1, tx_ready=1, busy=0, done=0, shift register=0, counter=0.
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_ready=1.
  - On tx_valid&&tx_ready: latch tx_data, compute the parity bit, go to SYNC.
  - tx_ready and busy update on the next edge (tx_ready=0, busy=1).
  - A baud tick in the same cycle as the handshake is ignored.
- SYNC: tx stays 1. On the next baud go to START and drive tx=0. Every bit therefore lasts exactly one full baud interval.
- START: on baud go to DATA, tx=shreg[0], counter=0.
- DATA: on each baud:
  - if counter==DATA_BITS-1, leave DATA;
  - else shift right, counter+1, tx=next bit.
  - On leaving: go to PARITY if the feature is compiled in, else STOP; counter=0.
- PARITY: tx=parity bit. On baud go to STOP with tx=1.
- STOP: tx=1; counter counts stop periods. On the baud that ends period STOP_BITS:
  - go to IDLE;
  - done=1 for exactly that one cycle;
  - busy=0 and tx_ready=1 from the next cycle.
- Back-to-back frames: tx_valid held high gives a handshake on the first IDLE cycle, then SYNC. Minimum inter-frame gap is stop bits plus the SYNC wait, with no extra idle bit beyond SYNC.
- tx_data and parity_odd changes outside the handshake cycle have no effect on the frame in flight.
- Outside IDLE, tx_valid is ignored (tx_ready=0).
- baud pulses longer than 1 clk are out of spec. Behaviour is defined per cycle: each high cycle counts as a tick.
- Reset mid-frame: tx returns to 1 asynchronously, the frame is abandoned, and there is no done pulse.
- Frame length in baud intervals, from the tick that drives the start bit to the tick that ends the final stop bit: 1 + DATA_BITS + P + STOP_BITS, where P=1 with parity and 0 without.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state present; parity bit = ^tx_data XOR parity_odd, computed at handshake.
- Undefined: PARITY state, parity register and parity_odd logic are absent. DATA goes straight to STOP; parity_odd is left unconnected internally (port retained).

Decomposition:
- Shared package uart_pkg holds:
  - state enum/localparams (IDLE..STOP);
  - TX_IDLE_LEVEL=1'b1;
  - legal DATA_BITS/STOP_BITS range constants for elaboration checks.
- One sub-module: uart_bit_counter, a CNT_W-bit counter with clear, enable-on-baud and terminal-count compare. It is instantiated once and reused for DATA and STOP.

Test Plan:
- Reset, then no traffic for 100 clks -> tx=1, tx_ready=1, busy=0, done never asserted.
- DATA_BITS=8, no parity, baud every 16 clks, send 0xA5 -> tx after SYNC reads 0,1,0,1,0,0,1,0,1,1, one value per 16 clks. done pulses once, exactly 1 clk wide.
- UART_TX_PARITY_EN, parity_odd=0, send 0x07 -> parity bit=1. With parity_odd=1, send 0x03 -> parity bit=1.
- STOP_BITS=2, tx_valid held high with 0x55 then 0xAA -> two frames each with 2 stop periods. tx_ready pulses for 1 clk between them, and the second start bit follows the first baud after re-entering IDLE.
- Handshake in the same cycle as baud -> that tick is ignored; start bit begins on the following tick and lasts a full interval.
- Assert reset_n low during bit 3 of DATA -> tx=1 immediately, state IDLE, no done. A new frame after release is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Desc     : Shared UART TX types, line levels and legal parameter ranges.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = ~TX_IDLE_LEVEL;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Number of baud intervals from the start-bit tick to the end of the last stop bit.
    function automatic int frame_len(input int data_bits, input int parity_bits,
                                     input int stop_bits);
        return 1 + data_bits + parity_bits + stop_bits;
    endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_bit_counter.sv
// ============================================================================
// Module   : uart_bit_counter
// Desc     : Bit/period counter with synchronous clear, enable and terminal compare.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule : uart_bit_counter

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// ============================================================================
// Module   : uart_tx_engine
// Desc     : UART transmit engine: handshake, baud-aligned LSB-first serialiser.
//            Optional parity bit compiled in with UART_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    generate
        if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
            $error("uart_tx_engine: DATA_BITS out of range");
        end
        if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
            $error("uart_tx_engine: STOP_BITS out of range");
        end
        if ((1 << CNT_W) <= DATA_BITS) begin : g_bad_cnt_w
            $error("uart_tx_engine: CNT_W too narrow for DATA_BITS");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   cnt_clr;
    logic                   cnt_en;
    logic                   cnt_tc;
    logic [CNT_W-1:0]       cnt_term;

`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`else
    logic                   unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // One counter serves both the data bits and the stop periods.
    assign cnt_term = (state_q == ST_STOP) ? STOP_LAST : DATA_LAST;

    uart_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .term_i  (cnt_term),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                tx_d    = TX_IDLE_LEVEL;
                ready_d = 1'b1;
                // A baud tick coinciding with the handshake is deliberately not consumed.
                if (tx_valid && ready_q) begin
                    shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^tx_data) ^ parity_odd;
`endif
                    cnt_clr = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (baud) begin
                    tx_d    = TX_START_LEVEL;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (baud) begin
                    tx_d    = shreg_q[0];
                    cnt_clr = 1'b1;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud) begin
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = TX_IDLE_LEVEL;
                        state_d = ST_STOP;
`endif
                    end else begin
                        shreg_d = shreg_q >> 1;
                        cnt_en  = 1'b1;
                        tx_d    = shreg_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud) begin
                    tx_d    = TX_IDLE_LEVEL;
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                tx_d = TX_IDLE_LEVEL;
                if (baud) begin
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_en  = 1'b1;
                    end
                end
            end

            default: begin
                tx_d    = TX_IDLE_LEVEL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            tx_q    <= TX_IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : uart_tx_engine

`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
// ============================================================================
// Module   : tb_uart_tx_engine
// Desc     : Scoreboard bench for uart_tx_engine (DATA_BITS=8, STOP_BITS=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_engine;

    localparam int DB = 8;
    localparam int SB = 2;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME_LEN = 1 + DB + PB + SB;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          baud       = 1'b0;
    logic [DB-1:0] tx_data    = '0;
    logic          tx_valid   = 1'b0;
    logic          parity_odd = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    logic          done;

    int n_cmp      = 0;
    int n_err      = 0;
    int done_cnt   = 0;
    int n_done_exp = 0;
    bit exp_q[$];
    bit in_frame   = 1'b0;
    int nbits      = 0;

    uart_tx_engine #(
        .DATA_BITS (DB),
        .STOP_BITS (SB),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud       (baud),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_odd (parity_odd),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Baud tick every 16 clocks, driven on the falling edge.
    initial begin
        forever begin
            repeat (15) @(negedge clk);
            baud = 1'b1;
            @(negedge clk);
            baud = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Receiver: each bit value is the line level during the cycle whose edge carries the tick.
    initial begin
        bit prev_tx, prev_baud, have_prev, glitch, done_now, done_low, e;
        have_prev = 0; glitch = 0; done_now = 0; done_low = 0;
        forever begin
            step();
            if (!reset_n) begin
                in_frame  = 0;
                nbits     = 0;
                glitch    = 0;
                have_prev = 0;
                done_now  = 0;
                done_low  = 0;
                exp_q.delete();
                continue;
            end
            if (have_prev && !prev_baud && (tx !== prev_tx)) glitch = 1;
            if (done_now) begin
                check("done_hi", done, 1);
                done_now = 0;
                done_low = 1;
            end else if (done_low) begin
                check("done_1clk", done, 0);
                done_low = 0;
            end
            if (done) done_cnt++;
            if (baud) begin
                if (!in_frame && tx == 1'b0) begin
                    in_frame = 1;
                    nbits    = 0;
                end
                if (in_frame) begin
                    if (exp_q.size() == 0) begin
                        check("sb_empty", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("bit", tx, e);
                    end
                    check("bit_stable", glitch, 0);
                    nbits++;
                    if (nbits == FRAME_LEN) begin
                        in_frame = 0;
                        done_now = 1;
                    end
                end
                glitch = 0;
            end
            prev_tx   = tx;
            prev_baud = baud;
            have_prev = 1;
        end
    end

    task automatic send(input logic [DB-1:0] d, input logic podd, input bit align, input bit hold);
        int lim;
        int tk;
        int lat;
        tx_data    = d;
        parity_odd = podd;
        lim        = 0;
        if (align) begin
            tx_valid = 1'b0;
            while (!(tx_ready && baud) && lim < 1000) begin step(); lim++; end
        end else begin
            tx_valid = 1'b1;
            while (!tx_ready && lim < 1000) begin step(); lim++; end
        end
        if (!tx_ready) begin
            check("hs_timeout", 0, 1);
            tx_valid = 1'b0;
            return;
        end
        tx_valid = 1'b1;
        exp_q.push_back(1'b0);
        for (int i = 0; i < DB; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back((^d) ^ podd);
`endif
        for (int i = 0; i < SB; i++) exp_q.push_back(1'b1);
        n_done_exp++;
        tk  = 0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k == 1) begin
                check("hs_ready_drop", tx_ready, 0);
                check("hs_busy", busy, 1);
                if (!hold) tx_valid = 1'b0;
                tx_data    = DB'($urandom);
                parity_odd = ~podd;
            end
            if (tx == 1'b0) begin
                lat = k;
                break;
            end
            if (tk == 0 && baud) tk = k;
        end
        check("start_lat", lat, tk + 1);
    endtask

    task automatic wait_idle();
        int lim;
        lim = 0;
        while ((busy || in_frame) && lim < 2000) begin step(); lim++; end
        check("idle_reached", busy, 0);
        repeat (3) step();
    endtask

    initial begin
        int bad_tx, bad_ready, bad_busy, lim;
        bad_tx = 0; bad_ready = 0; bad_busy = 0;

        step();
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1)       bad_tx++;
            if (tx_ready !== 1'b1) bad_ready++;
            if (busy !== 1'b0)     bad_busy++;
        end
        check("idle_tx", bad_tx, 0);
        check("idle_ready", bad_ready, 0);
        check("idle_busy", bad_busy, 0);
        check("idle_done", done_cnt, 0);

        send(8'hA5, 1'b0, 1'b0, 1'b0);
        wait_idle();
        check("done_after_a5", done_cnt, 1);

        send(8'h07, 1'b0, 1'b0, 1'b0);
        wait_idle();
        send(8'h03, 1'b1, 1'b0, 1'b0);
        wait_idle();

        send(8'h55, 1'b0, 1'b0, 1'b1);
        send(8'hAA, 1'b0, 1'b0, 1'b0);
        wait_idle();

        send(8'h96, 1'b1, 1'b1, 1'b0);
        wait_idle();

        send(8'h3C, 1'b0, 1'b0, 1'b0);
        lim = 0;
        while (!(in_frame && nbits == 4) && lim < 1000) begin step(); lim++; end
        check("reach_bit3", nbits, 4);
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_ready", tx_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        n_done_exp--;
        step();
        step();
        reset_n = 1'b1;
        step();
        check("postrst_tx", tx, 1);
        send(8'hC3, 1'b1, 1'b0, 1'b0);
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            send(DB'($urandom), 1'($urandom), 1'b0, 1'b0);
            wait_idle();
        end

        check("done_count", done_cnt, n_done_exp);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_engine

`default_nettype wire
